// File: rtl/status_flags_if.sv
// Bus between the core sequencer/ALU and the processor status register.
//   master : sequencer side, drives issue strobes, ALU flags, DI and selects
//   slave  : status_flags side, returns P, P_push and cond_true
interface status_flags_if #(
  parameter int unsigned dw = 16
) ();
  logic          RDY;
  logic          upd_nz;
  logic          upd_c;
  logic          upd_v;
  logic          bit_op;
  logic          alu_co;
  logic          alu_v;
  logic          alu_z;
  logic          alu_n;
  logic [dw-1:0] DI;
  logic          plp;
  logic [2:0]    flag_op;
  logic          irq_take;
  logic          brk;
  logic [2:0]    cond;
  logic [7:0]    P;
  logic [7:0]    P_push;
  logic          cond_true;

  modport master (
    output RDY, upd_nz, upd_c, upd_v, bit_op, alu_co, alu_v, alu_z, alu_n,
    output DI, plp, flag_op, irq_take, brk, cond,
    input  P, P_push, cond_true
  );

  modport slave (
    input  RDY, upd_nz, upd_c, upd_v, bit_op, alu_co, alu_v, alu_z, alu_n,
    input  DI, plp, flag_op, irq_take, brk, cond,
    output P, P_push, cond_true
  );
endinterface

// File: rtl/status_flags.sv
// Processor status register P = {N,V,1,B,D,I,Z,C} for the 6502/65Org16 core.
// ALU flag updates are two-stage: the issue edge records which flags are pending,
// the next RDY edge copies the ALU's registered flags into P. PLP, flag set/clear
// and interrupt entry act on the next edge directly.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset (P = 8'h34)
//   bus   : status_flags_if slave modport (issue strobes, ALU flags, DI, plp,
//           flag_op, irq_take, brk, cond in; P, P_push, cond_true out)
module status_flags #(
  parameter int unsigned dw = 16
) (
  input logic           clk,
  input logic           reset,
  status_flags_if.slave bus
);

  localparam logic [7:0] PReset = 8'h34;

  // Bit positions within P
  localparam int unsigned BitC = 0;
  localparam int unsigned BitZ = 1;
  localparam int unsigned BitI = 2;
  localparam int unsigned BitD = 3;
  localparam int unsigned BitB = 4;
  localparam int unsigned Bit1 = 5;
  localparam int unsigned BitV = 6;
  localparam int unsigned BitN = 7;

  logic [7:0] r_p;
  logic       r_pend_nz;
  logic       r_pend_c;
  logic       r_pend_v;
  logic       r_pend_bit;
  logic [1:0] r_bit_nv;   // {DI[dw-1], DI[dw-2]} captured on a BIT issue edge
  logic [7:0] w_p_nxt;
  logic       w_unused_di;

  // Only DI[7:0] and the BIT taps are consumed.
  assign w_unused_di = ^bus.DI;

  // Priority: pending ALU flags < PLP < flag_op < interrupt entry.
  always_comb begin
    w_p_nxt = r_p;
    if (r_pend_nz) begin
      w_p_nxt[BitZ] = bus.alu_z;
      w_p_nxt[BitN] = r_pend_bit ? r_bit_nv[1] : bus.alu_n;
    end
    if (r_pend_c) begin
      w_p_nxt[BitC] = bus.alu_co;
    end
    if (r_pend_v) begin
      w_p_nxt[BitV] = r_pend_bit ? r_bit_nv[0] : bus.alu_v;
    end
    if (bus.plp) begin
      w_p_nxt = {bus.DI[7:6], 1'b1, bus.DI[4:0]};
    end
    case (bus.flag_op)
      3'd1:    w_p_nxt[BitC] = 1'b0;
      3'd2:    w_p_nxt[BitC] = 1'b1;
      3'd3:    w_p_nxt[BitI] = 1'b0;
      3'd4:    w_p_nxt[BitI] = 1'b1;
      3'd5:    w_p_nxt[BitD] = 1'b0;
      3'd6:    w_p_nxt[BitD] = 1'b1;
      3'd7:    w_p_nxt[BitV] = 1'b0;
      default: ;
    endcase
    if (bus.irq_take) begin
      w_p_nxt[BitI] = 1'b1;
      w_p_nxt[BitD] = 1'b0;
    end
    w_p_nxt[Bit1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p        <= PReset;
      r_pend_nz  <= 1'b0;
      r_pend_c   <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_bit <= 1'b0;
      r_bit_nv   <= 2'b00;
    end else if (bus.RDY) begin
      r_p        <= w_p_nxt;
      r_pend_nz  <= bus.upd_nz | bus.bit_op;
      r_pend_c   <= bus.upd_c;
      r_pend_v   <= bus.upd_v | bus.bit_op;
      r_pend_bit <= bus.bit_op;
      if (bus.bit_op) begin
        r_bit_nv <= {bus.DI[dw-1], bus.DI[dw-2]};
      end
    end
  end

  assign bus.P      = r_p;
  // The pushed copy carries the BRK/IRQ distinction instead of the stored B.
  assign bus.P_push = {r_p[7:5], bus.brk, r_p[3:0]};

  // Branch test on the current P only; no bypass of pending flags.
  always_comb begin
    bus.cond_true = 1'b0;
    case (bus.cond)
      3'd0:    bus.cond_true = ~r_p[BitN];
      3'd1:    bus.cond_true =  r_p[BitN];
      3'd2:    bus.cond_true = ~r_p[BitV];
      3'd3:    bus.cond_true =  r_p[BitV];
      3'd4:    bus.cond_true = ~r_p[BitC];
      3'd5:    bus.cond_true =  r_p[BitC];
      3'd6:    bus.cond_true = ~r_p[BitZ];
      default: bus.cond_true =  r_p[BitZ];
    endcase
  end

endmodule

// File: tb/tb_status_flags.sv
module tb_status_flags;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  status_flags_if #(.dw(16)) bus_if ();

  status_flags #(.dw(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        plp;
    logic [15:0] di;
    logic [2:0]  flag_op;
    logic        irq;
    logic        brk;
    logic [2:0]  cond;
    logic [7:0]  exp_p;
    logic [7:0]  exp_push;
    logic        exp_cond;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.RDY      = 1'b1;
    bus_if.upd_nz   = 1'b0;
    bus_if.upd_c    = 1'b0;
    bus_if.upd_v    = 1'b0;
    bus_if.bit_op   = 1'b0;
    bus_if.DI       = 16'h0000;
    bus_if.plp      = 1'b0;
    bus_if.flag_op  = 3'd0;
    bus_if.irq_take = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{1'b0, 16'h0000, 3'd2, 1'b0, 1'b1, 3'd5, 8'h35, 8'h35, 1'b1}; // SEC
    vecs[1] = '{1'b0, 16'h0000, 3'd6, 1'b0, 1'b0, 3'd4, 8'h3D, 8'h2D, 1'b0}; // SED
    vecs[2] = '{1'b0, 16'h0000, 3'd3, 1'b0, 1'b1, 3'd0, 8'h39, 8'h39, 1'b1}; // CLI
    vecs[3] = '{1'b1, 16'h00C3, 3'd0, 1'b0, 1'b1, 3'd1, 8'hE3, 8'hF3, 1'b1}; // PLP
    vecs[4] = '{1'b0, 16'h0000, 3'd7, 1'b0, 1'b0, 3'd3, 8'hA3, 8'hA3, 1'b0}; // CLV
    vecs[5] = '{1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 3'd6, 8'hA7, 8'hB7, 1'b0}; // IRQ
    vecs[6] = '{1'b0, 16'h0000, 3'd6, 1'b1, 1'b0, 3'd7, 8'hA7, 8'hA7, 1'b1}; // SED+IRQ
    vecs[7] = '{1'b1, 16'hFF04, 3'd0, 1'b0, 1'b1, 3'd2, 8'h24, 8'h34, 1'b1}; // PLP hi ignored
    vecs[8] = '{1'b1, 16'h0001, 3'd1, 1'b0, 1'b0, 3'd5, 8'h20, 8'h20, 1'b0}; // PLP+CLC
    vecs[9] = '{1'b0, 16'h0000, 3'd2, 1'b0, 1'b1, 3'd4, 8'h21, 8'h31, 1'b0}; // SEC

    idle();
    bus_if.alu_co = 1'b0;
    bus_if.alu_v  = 1'b0;
    bus_if.alu_z  = 1'b0;
    bus_if.alu_n  = 1'b0;
    bus_if.brk    = 1'b1;
    bus_if.cond   = 3'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_p", bus_if.P, 8'h34);
    step();
    chk("reset_hold_p", bus_if.P, 8'h34);
    chk("reset_push", bus_if.P_push, 8'h34);

    // Single-edge operations from the table
    for (int i = 0; i < 10; i++) begin
      idle();
      bus_if.plp      = vecs[i].plp;
      bus_if.DI       = vecs[i].di;
      bus_if.flag_op  = vecs[i].flag_op;
      bus_if.irq_take = vecs[i].irq;
      bus_if.brk      = vecs[i].brk;
      bus_if.cond     = vecs[i].cond;
      step();
      chk($sformatf("vec%0d_p", i), bus_if.P, vecs[i].exp_p);
      chk($sformatf("vec%0d_push", i), bus_if.P_push, vecs[i].exp_push);
      chk($sformatf("vec%0d_cond", i), {7'b0, bus_if.cond_true}, {7'b0, vecs[i].exp_cond});
    end
    idle();
    bus_if.brk = 1'b1;

    // Reset mid-run with a carry update pending
    bus_if.upd_c = 1'b1;
    step();
    idle();
    bus_if.alu_co = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_reset_async", bus_if.P, 8'h34);
    step();
    reset = 1'b0;
    step();
    chk("after_reset_1", bus_if.P, 8'h34);
    step();
    chk("after_reset_2", bus_if.P, 8'h34);
    bus_if.alu_co = 1'b0;

    // ALU N/Z/C update lands on the apply edge, not the issue edge
    bus_if.upd_nz = 1'b1;
    bus_if.upd_c  = 1'b1;
    step();
    idle();
    bus_if.alu_n  = 1'b1;
    bus_if.alu_z  = 1'b0;
    bus_if.alu_co = 1'b1;
    chk("alu_issue_edge", bus_if.P, 8'h34);
    // Back-to-back: op2 (upd_c) issued on op1 (upd_nz) apply edge
    step();
    chk("alu_apply_edge", bus_if.P, 8'hB5);
    bus_if.upd_nz = 1'b1;
    step();
    chk("alu_hold_no_pend", bus_if.P, 8'hB5);
    idle();
    bus_if.upd_c = 1'b1;
    bus_if.alu_n = 1'b0;
    bus_if.alu_z = 1'b1;
    step();
    chk("b2b_op1_lands", bus_if.P, 8'h37);
    idle();
    bus_if.alu_co = 1'b0;
    step();
    chk("b2b_op2_lands", bus_if.P, 8'h36);

    // BIT with DI=16'h4000: N/V from operand taps, Z from ALU
    bus_if.bit_op = 1'b1;
    bus_if.DI     = 16'h4000;
    step();
    idle();
    bus_if.alu_z = 1'b1;
    bus_if.alu_n = 1'b1;
    bus_if.alu_v = 1'b0;
    bus_if.cond  = 3'd7;
    step();
    chk("bit_p", bus_if.P, 8'h76);
    chk("bit_beq", {7'b0, bus_if.cond_true}, 8'h01);
    bus_if.cond = 3'd3;
    #1;
    chk("bit_bvs", {7'b0, bus_if.cond_true}, 8'h01);
    bus_if.alu_n = 1'b0;
    bus_if.alu_z = 1'b0;

    // RDY low for 3 edges holds P and the pending carry
    bus_if.upd_c = 1'b1;
    step();
    idle();
    bus_if.RDY     = 1'b0;
    bus_if.alu_co  = 1'b1;
    bus_if.plp     = 1'b1;
    bus_if.flag_op = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rdy_low_%0d", i), bus_if.P, 8'h76);
    end
    idle();
    step();
    chk("rdy_resume", bus_if.P, 8'h77);

    // Pending C=1 coincident with CLC: CLC wins
    bus_if.upd_c = 1'b1;
    step();
    idle();
    bus_if.flag_op = 3'd1;
    step();
    chk("pend_c_vs_clc", bus_if.P, 8'h76);
    idle();
    step();
    chk("pend_cleared", bus_if.P, 8'h76);
    bus_if.alu_co = 1'b0;

    // Interrupt entry and SEI/CLI back-to-back
    bus_if.flag_op = 3'd3;
    step();
    chk("cli", bus_if.P, 8'h72);
    bus_if.flag_op = 3'd6;
    step();
    chk("sed", bus_if.P, 8'h7A);
    idle();
    bus_if.irq_take = 1'b1;
    step();
    chk("irq_take", bus_if.P, 8'h76);
    idle();
    bus_if.flag_op = 3'd4;
    step();
    chk("sei", bus_if.P, 8'h76);
    bus_if.flag_op = 3'd3;
    step();
    chk("sei_cli", bus_if.P, 8'h72);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
